// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle core control FSM.
package ctrl_pkg;

    // Main controller states; encodings 10..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        TRAP      = 4'd9
    } state_t;

    // Supported instruction opcodes (instruction[6:0]).
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALUOp encodings seen by the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B mux selects.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // Full datapath control word produced per state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_source;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_word_t;

    // True for opcodes that go through the address-calculation state.
    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Pure combinational decode of the FSM state (and mem_ready) into the control word.
module ctrl_word_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    // Per-state control word; everything not named in a state stays 0.
    always_comb begin
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = 1'b0;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            default: ctrl = '0;   // TRAP and unused encodings: no enables, no requests
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle core: state register, next-state logic,
// sticky trap flag and reset-gated control outputs.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic       ALUOp0,
    output logic       ALUOp1,
    output logic       instr_done,
    output logic       trap
);

    state_t     state_q, state_d;
    logic       trap_q, trap_d;
    ctrl_word_t ctrl_raw;
    ctrl_word_t ctrl;

    // State and sticky trap registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
        end
    end

    // Next-state sequencing; opcode is only looked at in DECODE and MEM_ADDR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:     state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (is_mem_op(opcode))    state_d = MEM_ADDR;
                else if (opcode == OP_R)  state_d = EXECUTE;
                else if (opcode == OP_BEQ) state_d = BRANCH;
                else                      state_d = TRAP;
            end
            MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = MEM_READ;
                else if (opcode == OP_SW) state_d = MEM_WRITE;
                else                      state_d = TRAP;
            end
            MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    state_d = FETCH;
            MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   state_d = ALU_WB;
            ALU_WB:    state_d = FETCH;
            BRANCH:    state_d = FETCH;
            TRAP:      state_d = TRAP;
            default:   state_d = FETCH;
        endcase
        trap_d = trap_q | (state_d == TRAP);
    end

    ctrl_word_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset forces every output low so an in-flight access cannot complete.
    always_comb begin
        ctrl = rst ? '0 : ctrl_raw;
        PCWrite     = ctrl.pc_write;
        PCWriteCond = ctrl.pc_write_cond;
        IorD        = ctrl.iord;
        MemRead     = ctrl.mem_read;
        MemWrite    = ctrl.mem_write;
        IRWrite     = ctrl.ir_write;
        MemtoReg    = ctrl.mem_to_reg;
        RegWrite    = ctrl.reg_write;
        ALUSrcA     = ctrl.alu_src_a;
        ALUSrcB     = ctrl.alu_src_b;
        PCSource    = ctrl.pc_source;
        ALUOp0      = ctrl.alu_op[0];
        ALUOp1      = ctrl.alu_op[1];
        instr_done  = ctrl.instr_done;
        trap        = trap_q & ~rst;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, ALUSrcA, PCSource, ALUOp0, ALUOp1;
    logic       instr_done, trap;
    logic [1:0] ALUSrcB;

    int checks = 0;
    int errors = 0;

    // Output vector bit order:
    // PCWrite PCWriteCond IorD MemRead | MemWrite IRWrite MemtoReg RegWrite |
    // ALUSrcA ALUSrcB[1:0] PCSource | ALUOp1 ALUOp0 instr_done trap
    localparam logic [15:0] E_ZERO = 16'b0000_0000_0000_0000;
    localparam logic [15:0] E_F1   = 16'b1001_0100_0010_0000;
    localparam logic [15:0] E_F0   = 16'b0001_0000_0010_0000;
    localparam logic [15:0] E_DEC  = 16'b0000_0000_0100_0000;
    localparam logic [15:0] E_MA   = 16'b0000_0000_1100_0000;
    localparam logic [15:0] E_MR   = 16'b0011_0000_0000_0000;
    localparam logic [15:0] E_MWB  = 16'b0000_0011_0000_0010;
    localparam logic [15:0] E_MW0  = 16'b0010_1000_0000_0000;
    localparam logic [15:0] E_MW1  = 16'b0010_1000_0000_0010;
    localparam logic [15:0] E_EX   = 16'b0000_0000_1000_1000;
    localparam logic [15:0] E_AWB  = 16'b0000_0001_0000_0010;
    localparam logic [15:0] E_BR   = 16'b0100_0000_1001_0110;
    localparam logic [15:0] E_TRP  = 16'b0000_0000_0000_0001;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        mr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    multicycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ALUOp0      (ALUOp0),
        .ALUOp1      (ALUOp1),
        .instr_done  (instr_done),
        .trap        (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, ALUOp1, ALUOp0, instr_done, trap};
    endfunction

    task automatic add(input logic r, input logic [6:0] op, input logic mr,
                       input logic [15:0] exp, input string name);
        vec_t v;
        v.rst = r; v.op = op; v.mr = mr; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs at the falling edge, check just after.
    task automatic step(input logic r, input logic [6:0] op, input logic mr,
                        input logic [15:0] exp, input string name);
        logic [15:0] got;
        @(negedge clk);
        rst = r; opcode = op; mem_ready = mr;
        #1;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
        checks++;
        if (MemRead === 1'b1 && MemWrite === 1'b1) begin
            errors++;
            $display("FAIL %s_rw_excl: got MemRead=1 MemWrite=1 expected not both", name);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = '0; mem_ready = 1'b1;

        // Reset held 3 cycles, then first FETCH
        add(1, '0, 1, E_ZERO, "rst0");
        add(1, '0, 1, E_ZERO, "rst1");
        add(1, '0, 1, E_ZERO, "rst2");
        add(0, '0, 1, E_F1,   "fetch_after_rst");
        // R-type, opcode garbage outside DECODE ignored, mem_ready ignored in ALU_WB
        add(0, R,   1, E_DEC, "r_dec");
        add(0, BAD, 1, E_EX,  "r_ex");
        add(0, BAD, 0, E_AWB, "r_wb");
        // lw with two wait cycles in MEM_READ
        add(0, LW, 1, E_F1,  "lw_fetch");
        add(0, LW, 0, E_DEC, "lw_dec");
        add(0, LW, 0, E_MA,  "lw_ma");
        add(0, LW, 0, E_MR,  "lw_mr_wait0");
        add(0, LW, 0, E_MR,  "lw_mr_wait1");
        add(0, LW, 1, E_MR,  "lw_mr_done");
        add(0, LW, 0, E_MWB, "lw_wb");
        // sw with a fetch stall and one write wait cycle
        add(0, SW, 0, E_F0,  "sw_fetch_stall");
        add(0, SW, 1, E_F1,  "sw_fetch");
        add(0, SW, 1, E_DEC, "sw_dec");
        add(0, SW, 1, E_MA,  "sw_ma");
        add(0, SW, 0, E_MW0, "sw_mw_wait");
        add(0, SW, 1, E_MW1, "sw_mw_done");
        // beq: three cycles
        add(0, BEQ, 1, E_F1,  "beq_fetch");
        add(0, BEQ, 1, E_DEC, "beq_dec");
        add(0, BEQ, 1, E_BR,  "beq_br");
        add(0, '0,  1, E_F1,  "after_beq");

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].exp, vecs[i].name);

        // Illegal opcode: trap next cycle, absorbing for 20 cycles, cleared by rst
        step(0, BAD, 1, E_DEC, "bad_dec");
        for (int i = 0; i < 20; i++)
            step(0, 7'($urandom), 1'($urandom), E_TRP, "trap_hold");
        step(1, '0, 1, E_ZERO, "trap_rst");
        step(0, '0, 1, E_F1,   "trap_cleared_fetch");

        // Reset in the middle of a stalled store: no write, no retire
        step(0, SW, 1, E_DEC, "rst_sw_dec");
        step(0, SW, 1, E_MA,  "rst_sw_ma");
        step(0, SW, 0, E_MW0, "rst_sw_mw");
        step(1, SW, 0, E_ZERO, "rst_sw_abort");
        step(0, SW, 0, E_F0,  "rst_sw_refetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
